multdiv_tracker: RTL and testbench
==================================

Name: multdiv_tracker

Overview:
- Producer side of the multi-cycle mul/div hazard interface consumed by the pipeline controller.
- Tracks every in-flight mul/div through a fixed 17-stage occupancy pipe (P0..P16).
- Drives per-stage busy, per-stage bypass-request and unresolved-exception status to the stall/bypass logic.
- Issues a writeback request/grant handshake when an op reaches P16.

Parameters:
- DEPTH, 17, number of tracked stages; P16 = DEPTH-1 is the result/writeback stage.
- RD_W, 5, register-specifier width.

Ports:
- clock  in  1  single system clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- issue_valid  in  1  X-stage instruction is a mul/div accepted this cycle.
- issue_insn  in  32  X-stage instruction word; rd = [26:22], ALU op = [6:2] (6 = mul, 7 = div).
- flush  in  1  squash all in-flight entries.
- src_rs  in  RD_W  DX consumer rs.
- src_rt  in  RD_W  DX consumer rt.
- src_rd  in  RD_W  DX consumer rd, for reads by bne/blt/sw/jr.
- src_use  in  3  read mask {rd, rt, rs}.
- wb_grant  in  1  W port accepts the P16 result this cycle.
- result_exc  in  1  arithmetic unit flags exception for the P16 op (feature only).
- busy_stage  out  DEPTH  bit k = stage Pk occupied.
- bp_reqX  out  DEPTH  bit k = Pk occupied and its rd matches an active DX source.
- exc_piped  out  1  unresolved mul/div may still raise an exception.
- wb_req  out  1  P16 occupied.
- wb_rd  out  RD_W  rd of the P16 entry.
- wb_is_div  out  1  P16 entry is a div.
- issue_stall  out  1  pipe frozen; issue is refused.
- inflight_cnt  out  5  number of occupied stages, 0..17.
- exc_out  out  1  registered exception pulse on retire (feature only).

Behaviour:
- Reset (clrn = 0, asynchronous): all entries invalid; all outputs 0. Reset may be asserted mid-operation and takes effect immediately, with no pending retire.
- Entry fields: valid, rd[4:0], is_div, plus exc when the feature is built.
- frozen = valid[P16] & ~wb_grant. Cycle-level rules:
  - Not frozen: every entry shifts Pk -> Pk+1 on the rising edge. P16 retires (drops) when wb_req & wb_grant.
  - Frozen: all entries hold; issue_stall = 1.
  - issue_stall is combinational and equals frozen.
- Issue:
  - issue_valid & ~issue_stall & ~flush loads P0 on the next edge with rd = issue_insn[26:22] and is_div = (op == 7).
  - issue_valid while stalled is ignored; the controller must hold X.
- Latency: an op issued at edge N is in P16 (wb_req = 1) at edge N+16 with no freezes. Each frozen cycle adds one.
- Retire: wb_req, wb_rd and wb_is_div are direct from P16. Retire happens in the same cycle as shift-in of P15; no bubble.
- bp_reqX[k] = valid[k] & (rd[k] != 0) & ((src_use[0] & rd[k] == src_rs) | (src_use[1] & rd[k] == src_rt) | (src_use[2] & rd[k] == src_rd)). Combinational.
- Writes to r0 are tracked and retired normally but never raise bp_reqX.
- WAW (same rd in several stages): all matching stages assert bp_reqX; ordering is preserved by the shift pipe.
- flush: synchronous; clears every valid bit on the next edge. Priority is flush > retire > issue, and a same-cycle issue is dropped. A flush while frozen still clears, and wb_req falls next cycle.
- inflight_cnt: registered counter; +1 on accepted issue, -1 on retire; both in one cycle gives no change; flush sets it to 0. It must always equal popcount(busy_stage). Max 17 (DEPTH); with P16 full and frozen, no issue is possible, so it cannot overflow.
- exc_piped = OR of valid[] when the feature is built, else 0.

Optional Feature:
- MULTDIV_EXC_EN defined:
  - Each entry carries exc, captured from result_exc while the entry is in P16.
  - exc_out pulses 1 cycle after a retire whose exc = 1.
  - exc_piped = |valid[], so the controller holds bex until all mul/div resolve.
- Undefined:
  - result_exc ignored; exc_out and exc_piped tied to 0.
  - No exc storage is synthesised.

Test Plan:
- Reset mid-flight: issue mul rd = 5, drop clrn at stage P7 -> all outputs 0 asynchronously; inflight_cnt = 0.
- Latency: issue mul rd = 3 at edge 0 with wb_grant = 1 -> busy_stage one-hot shifts; wb_req = 1, wb_rd = 3 exactly at edge 16; retire at edge 17; inflight_cnt returns to 0.
- Bypass match: div rd = 9 in P4, src_rs = 9 with src_use = 001 -> bp_reqX = 0x00010. Then src_rs = 0 and rd = 0 -> bp_reqX = 0.
- Freeze: P16 valid with wb_grant = 0 for 3 cycles -> issue_stall = 1, issue_valid ignored, all entries hold. Grant at cycle 4 -> retire with total latency 19.
- Flush with issue: 4 entries in flight, flush & issue_valid in the same cycle -> next cycle busy_stage = 0, inflight_cnt = 0, issued op not present.
- With MULTDIV_EXC_EN: div rd = 2 with result_exc = 1 at P16, granted -> exc_out = 1 for one cycle; exc_piped = 1 from issue until retire. Without the macro -> exc_out = exc_piped = 0 throughout.

Source files
------------

// File: rtl/multdiv_tracker.sv
// Occupancy/hazard tracker for in-flight multi-cycle mul/div ops: a 17-stage shift pipe
// with bypass requests and a P16 writeback handshake. Optional exception tracking: MULTDIV_EXC_EN.
module multdiv_tracker #(
  parameter int DEPTH = 17,
  parameter int RD_W  = 5
) (
  input  logic              clock,
  input  logic              clrn,
  input  logic              issue_valid,
  input  logic [31:0]       issue_insn,
  input  logic              flush,
  input  logic [RD_W-1:0]   src_rs,
  input  logic [RD_W-1:0]   src_rt,
  input  logic [RD_W-1:0]   src_rd,
  input  logic [2:0]        src_use,
  input  logic              wb_grant,
  input  logic              result_exc,
  output logic [DEPTH-1:0]  busy_stage,
  output logic [DEPTH-1:0]  bp_reqX,
  output logic              exc_piped,
  output logic              wb_req,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_is_div,
  output logic              issue_stall,
  output logic [4:0]        inflight_cnt,
  output logic              exc_out
);

  logic [DEPTH-1:0] vld_p;
  logic [DEPTH-1:0] div_p;
  logic [RD_W-1:0]  rd_p [DEPTH];
  logic [4:0]       cnt;
  logic             frozen;
  logic             retire;
  logic             accept;
  logic             issue_div;

  // A result waiting at P16 without a grant freezes the whole pipe.
  assign frozen    = vld_p[DEPTH-1] & ~wb_grant;
  assign retire    = vld_p[DEPTH-1] & wb_grant;
  assign accept    = issue_valid & ~frozen & ~flush;
  assign issue_div = (issue_insn[6:2] == 5'd7);

  // P0..P16 occupancy shift pipe
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      vld_p <= '0;
      div_p <= '0;
      for (int k = 0; k < DEPTH; k++) rd_p[k] <= '0;
    end else if (flush) begin
      vld_p <= '0;
    end else if (!frozen) begin
      vld_p   <= {vld_p[DEPTH-2:0], accept};
      div_p   <= {div_p[DEPTH-2:0], issue_div};
      rd_p[0] <= issue_insn[22 +: RD_W];
      for (int k = 1; k < DEPTH; k++) rd_p[k] <= rd_p[k-1];
    end
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn)      cnt <= '0;
    else if (flush) cnt <= '0;
    else            cnt <= cnt + {4'd0, accept} - {4'd0, retire};
  end

  // r0 destinations never request a bypass.
  always_comb begin
    bp_reqX = '0;
    for (int k = 0; k < DEPTH; k++) begin
      bp_reqX[k] = vld_p[k] & (rd_p[k] != '0) &
                   ((src_use[0] & (rd_p[k] == src_rs)) |
                    (src_use[1] & (rd_p[k] == src_rt)) |
                    (src_use[2] & (rd_p[k] == src_rd)));
    end
  end

`ifdef MULTDIV_EXC_EN
  logic exc_p16;
  logic exc_out_q;

  // Only the P16 occupant can collect an exception; a new occupant arrives clean.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      exc_p16   <= 1'b0;
      exc_out_q <= 1'b0;
    end else begin
      exc_out_q <= retire & ~flush & (exc_p16 | result_exc);
      if (flush || !frozen) exc_p16 <= 1'b0;
      else                  exc_p16 <= exc_p16 | result_exc;
    end
  end

  assign exc_out   = exc_out_q;
  assign exc_piped = |vld_p;
  logic unused_bits;
  assign unused_bits = ^{issue_insn[31:22+RD_W], issue_insn[21:7], issue_insn[1:0]};
`else
  assign exc_out   = 1'b0;
  assign exc_piped = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{issue_insn[31:22+RD_W], issue_insn[21:7], issue_insn[1:0], result_exc};
`endif

  assign busy_stage   = vld_p;
  assign wb_req       = vld_p[DEPTH-1];
  assign wb_rd        = rd_p[DEPTH-1];
  assign wb_is_div    = div_p[DEPTH-1];
  assign issue_stall  = frozen;
  assign inflight_cnt = cnt;

endmodule

// File: tb/tb_multdiv_tracker.sv
// Self-checking bench for multdiv_tracker: queue-of-ops reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_multdiv_tracker;
  localparam int DEPTH = 17;
  localparam int RD_W  = 5;

  logic              clock = 1'b0;
  logic              clrn;
  logic              issue_valid;
  logic [31:0]       issue_insn;
  logic              flush;
  logic [RD_W-1:0]   src_rs, src_rt, src_rd;
  logic [2:0]        src_use;
  logic              wb_grant;
  logic              result_exc;
  logic [DEPTH-1:0]  busy_stage, bp_reqX;
  logic              exc_piped, wb_req, wb_is_div, issue_stall, exc_out;
  logic [RD_W-1:0]   wb_rd;
  logic [4:0]        inflight_cnt;

  multdiv_tracker #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
    .clock(clock), .clrn(clrn), .issue_valid(issue_valid), .issue_insn(issue_insn),
    .flush(flush), .src_rs(src_rs), .src_rt(src_rt), .src_rd(src_rd), .src_use(src_use),
    .wb_grant(wb_grant), .result_exc(result_exc), .busy_stage(busy_stage), .bp_reqX(bp_reqX),
    .exc_piped(exc_piped), .wb_req(wb_req), .wb_rd(wb_rd), .wb_is_div(wb_is_div),
    .issue_stall(issue_stall), .inflight_cnt(inflight_cnt), .exc_out(exc_out)
  );

  always #5 clock = ~clock;

  // Reference model: each in-flight op knows its own stage number.
  typedef struct {
    logic [RD_W-1:0] rd;
    bit              is_div;
    int              stage;
    bit              exc;
  } op_t;

  op_t q[$];
  bit  m_exc_out;
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_insn(input logic [4:0] rd, input bit is_div);
    logic [31:0] w;
    w = $urandom;
    w[26:22] = rd;
    w[6:2] = is_div ? 5'd7 : 5'd6;
    return w;
  endfunction

  function automatic bit model_frozen();
    return (q.size() > 0) && (q[q.size()-1].stage == DEPTH-1) && !wb_grant;
  endfunction

  task automatic model_edge();
    op_t n;
    bit  fr;
    bit  rexc;
    rexc = 1'b0;
    if (!clrn) begin
      q.delete();
    end else begin
      fr = model_frozen();
      if (flush) begin
        q.delete();
      end else if (!fr) begin
        if (q.size() > 0 && q[q.size()-1].stage == DEPTH-1) begin
          rexc = q[q.size()-1].exc | result_exc;
          void'(q.pop_back());
        end
        foreach (q[i]) q[i].stage++;
        if (issue_valid) begin
          n.rd = issue_insn[26:22];
          n.is_div = (issue_insn[6:2] == 5'd7);
          n.stage = 0;
          n.exc = 1'b0;
          q.push_front(n);
        end
      end else if (result_exc) begin
        q[q.size()-1].exc = 1'b1;
      end
    end
    m_exc_out = rexc;
  endtask

  task automatic check_all();
    logic [DEPTH-1:0] e_busy, e_bp;
    bit e_wb;
    e_busy = '0;
    e_bp = '0;
    e_wb = 1'b0;
    foreach (q[i]) begin
      e_busy[q[i].stage] = 1'b1;
      if (q[i].rd != 0 &&
          ((src_use[0] && q[i].rd == src_rs) || (src_use[1] && q[i].rd == src_rt) ||
           (src_use[2] && q[i].rd == src_rd)))
        e_bp[q[i].stage] = 1'b1;
      if (q[i].stage == DEPTH-1) begin
        e_wb = 1'b1;
        chk("wb_rd", 32'(wb_rd), 32'(q[i].rd));
        chk("wb_is_div", 32'(wb_is_div), 32'(q[i].is_div));
      end
    end
    chk("busy_stage", 32'(busy_stage), 32'(e_busy));
    chk("bp_reqX", 32'(bp_reqX), 32'(e_bp));
    chk("wb_req", 32'(wb_req), 32'(e_wb));
    chk("issue_stall", 32'(issue_stall), 32'(model_frozen()));
    chk("inflight_cnt", 32'(inflight_cnt), 32'(q.size()));
`ifdef MULTDIV_EXC_EN
    chk("exc_piped", 32'(exc_piped), 32'(q.size() > 0));
    chk("exc_out", 32'(exc_out), 32'(m_exc_out));
`else
    chk("exc_piped", 32'(exc_piped), 32'd0);
    chk("exc_out", 32'(exc_out), 32'd0);
`endif
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic cycle();
    @(negedge clock);
    check_all();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  initial begin
    clrn = 1'b0; issue_valid = 1'b0; issue_insn = '0; flush = 1'b0;
    src_rs = '0; src_rt = '0; src_rd = '0; src_use = '0;
    wb_grant = 1'b1; result_exc = 1'b0; m_exc_out = 1'b0;

    repeat (2) cycle();
    chk("reset busy", 32'(busy_stage), 32'd0);
    chk("reset cnt", 32'(inflight_cnt), 32'd0);
    clrn = 1'b1;
    cycle();

    // Latency: issued at edge 0, visible at P16 after edge 16, retired at edge 17
    issue_valid = 1'b1; issue_insn = mk_insn(5'd3, 1'b0);
    cycle();
    issue_valid = 1'b0;
    chk("lat p0", 32'(busy_stage), 32'h00001);
    repeat (15) cycle();
    chk("lat edge15 wb_req", 32'(wb_req), 32'd0);
    chk("lat edge15 busy", 32'(busy_stage), 32'h08000);
    cycle();
    chk("lat edge16 wb_req", 32'(wb_req), 32'd1);
    chk("lat edge16 wb_rd", 32'(wb_rd), 32'd3);
    cycle();
    chk("lat retire wb_req", 32'(wb_req), 32'd0);
    chk("lat retire cnt", 32'(inflight_cnt), 32'd0);

    // Asynchronous reset with an op sitting in P7
    issue_valid = 1'b1; issue_insn = mk_insn(5'd5, 1'b0);
    cycle();
    issue_valid = 1'b0;
    repeat (7) cycle();
    chk("pre-reset busy", 32'(busy_stage), 32'h00080);
    clrn = 1'b0;
    q.delete();
    m_exc_out = 1'b0;
    #1;
    chk("async reset busy", 32'(busy_stage), 32'd0);
    chk("async reset cnt", 32'(inflight_cnt), 32'd0);
    chk("async reset wb_req", 32'(wb_req), 32'd0);
    cycle();
    clrn = 1'b1;
    cycle();

    // Bypass: div rd=9 in P4 matched by rs; then an r0 write never matches
    issue_valid = 1'b1; issue_insn = mk_insn(5'd9, 1'b1);
    cycle();
    issue_valid = 1'b0;
    repeat (4) cycle();
    src_rs = 5'd9; src_use = 3'b001;
    #1;
    chk("bp rd9 P4", 32'(bp_reqX), 32'h00010);
    issue_valid = 1'b1; issue_insn = mk_insn(5'd0, 1'b0);
    cycle();
    issue_valid = 1'b0; src_rs = 5'd0;
    #1;
    chk("bp r0", 32'(bp_reqX), 32'h00000);
    src_use = 3'b000;
    repeat (20) cycle();

    // Freeze: P16 held 3 cycles with no grant, issue refused meanwhile
    wb_grant = 1'b0;
    issue_valid = 1'b1; issue_insn = mk_insn(5'd11, 1'b1);
    cycle();
    issue_valid = 1'b0;
    repeat (16) cycle();
    chk("frz wb_req", 32'(wb_req), 32'd1);
    issue_valid = 1'b1; issue_insn = mk_insn(5'd12, 1'b0);
    repeat (3) cycle();
    chk("frz stall", 32'(issue_stall), 32'd1);
    chk("frz cnt", 32'(inflight_cnt), 32'd1);
    chk("frz busy", 32'(busy_stage), 32'h10000);
    chk("frz wb_is_div", 32'(wb_is_div), 32'd1);
    issue_valid = 1'b0; wb_grant = 1'b1;
    cycle();
    chk("frz retire wb_req", 32'(wb_req), 32'd0);
    chk("frz retire cnt", 32'(inflight_cnt), 32'd0);

    // Flush beats a same-cycle issue
    issue_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue_insn = mk_insn(5'(i + 1), i[0]);
      cycle();
    end
    chk("pre-flush cnt", 32'(inflight_cnt), 32'd4);
    flush = 1'b1; issue_insn = mk_insn(5'd7, 1'b0);
    cycle();
    flush = 1'b0; issue_valid = 1'b0;
    chk("flush busy", 32'(busy_stage), 32'd0);
    chk("flush cnt", 32'(inflight_cnt), 32'd0);
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_insn  = mk_insn(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      wb_grant    = ($urandom_range(0, 9) < 6);
      flush       = ($urandom_range(0, 59) == 0);
      result_exc  = 1'($urandom_range(0, 1));
      src_rs      = 5'($urandom_range(0, 7));
      src_rt      = 5'($urandom_range(0, 7));
      src_rd      = 5'($urandom_range(0, 7));
      src_use     = 3'($urandom_range(0, 7));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
